mrfm_iir_loader: RTL and testbench
==================================

MRFM_IIR_LOADER -- requirements
Module: mrfm_iir_loader

Interface
REQ-001 Parameter COEFF_ADDR, default `FR_MRFM_IIR_COEFF, serial register address for coefficient writes.
REQ-002 Parameter SHIFT_ADDR, default `FR_MRFM_IIR_SHIFT, serial register address for the shift write.
REQ-003 Parameter GAP, default 0, range 0..15; idle cycles inserted between consecutive serial writes.
REQ-004 clock  in  1  sole clock; all logic on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 stage_we  in  1  write one staging coefficient.
REQ-007 stage_addr  in  4  staging coefficient index.
REQ-008 stage_data  in  16  staging coefficient value.
REQ-009 shift_we  in  1  write staging shift value.
REQ-010 shift_data  in  8  staging shift value.
REQ-011 commit  in  1  single-cycle request to send all staged settings.
REQ-012 abort  in  1  synchronous cancel of an in-flight burst.
REQ-013 align_en  in  1  when 1, the burst waits for the next strobe_in.
REQ-014 strobe_in  in  1  filter sample strobe used for alignment.
REQ-015 serial_strobe  out  1  one-cycle write strobe to settings bus.
REQ-016 serial_addr  out  7  settings register address.
REQ-017 serial_data  out  32  settings register data.
REQ-018 busy  out  1  high in any non-IDLE state.
REQ-019 done  out  1  one-cycle pulse on burst completion.
REQ-020 dirty  out  1  staged contents differ from the last completed burst.
REQ-021 err  out  1  sticky; set by a rejected staging write or a rejected commit.

Function
REQ-022 Staging storage SHALL be 16x16 coefficient registers plus one 8-bit shift register, all written only when busy=0.
REQ-023 FSM states SHALL be IDLE, WAIT_ALIGN, SEND, GAP_WAIT; SEND issues 17 writes, index 0..15 coefficients, then index 16 shift.
REQ-024 IDLE + commit: align_en=0 -> SEND; align_en=1 -> WAIT_ALIGN; busy rises the next cycle.
REQ-025 WAIT_ALIGN SHALL leave for SEND on the first cycle strobe_in=1; the first serial_strobe follows one cycle later.
REQ-026 Coefficient write k: serial_addr=COEFF_ADDR, serial_data={12'd0,k[3:0],coeff[k]}.
REQ-027 Shift write: serial_addr=SHIFT_ADDR, serial_data={24'd0,shift}.
REQ-028 Serial writes SHALL be spaced GAP+1 cycles apart; no gap follows the last write.
REQ-029 serial_strobe SHALL be high for exactly one cycle per write; serial_addr/serial_data are 0 whenever serial_strobe=0.
REQ-030 Timing, align_en=0: commit at cycle 0 -> strobes at cycles 1+k*(GAP+1), k=0..16; done=1 and busy=0 in the cycle after the last strobe.
REQ-031 done SHALL clear dirty; any accepted stage_we or shift_we SHALL set dirty.
REQ-032 stage_we/shift_we/commit while busy=1 SHALL be ignored and SHALL set err.
REQ-033 An accepted commit SHALL clear err.
REQ-034 stage_we and commit in the same IDLE cycle: the write SHALL be accepted and its value included in the burst.
REQ-035 abort while busy SHALL return to IDLE next cycle with no further strobes; done stays 0 and dirty stays 1.
REQ-036 abort and commit in the same IDLE cycle: abort SHALL win; no burst starts.
REQ-037 commit in IDLE with nothing staged since the last burst SHALL still send all 17 writes.

Reset
REQ-038 reset SHALL immediately force IDLE, with serial_strobe, serial_addr, serial_data, busy, done, dirty, and err all 0.
REQ-039 reset SHALL clear all staging coefficients and shift to 0.
REQ-040 Assertion mid-burst SHALL stop strobes immediately; no done follows.

Verification
REQ-041 Stage coeff[3]=16'h1234, shift=8'd15, commit (GAP=0, align_en=0) -> 17 strobes at cycles 1..17; strobe 4 carries data 32'h00031234; strobe 17 carries addr SHIFT_ADDR and data 32'h0000000F; done at cycle 18; dirty 1->0.
REQ-042 GAP=3, commit -> strobe spacing 4 cycles, last strobe at cycle 65, done at cycle 66.
REQ-043 align_en=1, commit, strobe_in 10 cycles later -> no strobe before that; first strobe on the cycle after strobe_in.
REQ-044 stage_we during burst -> staging value unchanged, err=1; next accepted commit clears err.
REQ-045 abort after the 5th strobe -> no 6th strobe, busy=0 the next cycle, done never pulses, dirty=1.
REQ-046 reset pulse mid-burst -> outputs 0 asynchronously, staging reads back 0 on the next burst.

Source files
------------

// File: rtl/mrfm_iir_loader_if.sv
`default_nettype none
// ============================================================================
// mrfm_iir_loader_if : settings-bus write port (strobe, address, data)
// Rev 1.0
// ============================================================================
interface mrfm_iir_loader_if;
  logic        serial_strobe;
  logic [6:0]  serial_addr;
  logic [31:0] serial_data;

  modport master (
    output serial_strobe,
    output serial_addr,
    output serial_data
  );

  modport slave (
    input serial_strobe,
    input serial_addr,
    input serial_data
  );
endinterface
`default_nettype wire

// File: rtl/mrfm_iir_loader.sv
`default_nettype none
// ============================================================================
// mrfm_iir_loader : stages 16 IIR coefficients plus a shift, then bursts all 17
// settings writes onto the serial settings bus, optionally aligned to a strobe.
// Rev 1.0
// ============================================================================
`ifndef FR_MRFM_IIR_COEFF
`define FR_MRFM_IIR_COEFF 7'd40
`endif
`ifndef FR_MRFM_IIR_SHIFT
`define FR_MRFM_IIR_SHIFT 7'd41
`endif

module mrfm_iir_loader #(
  parameter logic [6:0]  COEFF_ADDR = `FR_MRFM_IIR_COEFF,
  parameter logic [6:0]  SHIFT_ADDR = `FR_MRFM_IIR_SHIFT,
  parameter int unsigned GAP        = 0
) (
  input  wire logic          clock,
  input  wire logic          reset,
  input  wire logic          stage_we,
  input  wire logic [3:0]    stage_addr,
  input  wire logic [15:0]   stage_data,
  input  wire logic          shift_we,
  input  wire logic [7:0]    shift_data,
  input  wire logic          commit,
  input  wire logic          abort,
  input  wire logic          align_en,
  input  wire logic          strobe_in,
  mrfm_iir_loader_if.master  settings,
  output logic               busy,
  output logic               done,
  output logic               dirty,
  output logic               err
);

  localparam logic [1:0] c_st_idle       = 2'd0;
  localparam logic [1:0] c_st_wait_align = 2'd1;
  localparam logic [1:0] c_st_send       = 2'd2;
  localparam logic [1:0] c_st_gap_wait   = 2'd3;
  localparam logic [4:0] c_last_idx      = 5'd16;
  localparam logic [3:0] c_gap_last      = (GAP == 0) ? 4'd0 : 4'(GAP - 1);

  logic [1:0]  r_state;
  logic [1:0]  w_next_state;
  logic [15:0] r_coeff [16];
  logic [7:0]  r_shift;
  logic [4:0]  r_idx;
  logic [3:0]  r_gap_cnt;
  logic        r_done;
  logic        r_dirty;
  logic        r_err;
  logic        w_busy;
  logic        w_accept_commit;
  logic        w_stage_accept;
  logic        w_reject;
  logic        w_last_write;

  assign w_accept_commit = (r_state == c_st_idle) && commit && !abort;
  assign w_stage_accept  = !w_busy && (stage_we || shift_we);
  assign w_reject        = w_busy && (stage_we || shift_we || commit);
  assign w_last_write    = (r_state == c_st_send) && (r_idx == c_last_idx) && !abort;

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; abort pre-empts every busy state
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_st_idle: begin
        if (w_accept_commit) begin
          w_next_state = align_en ? c_st_wait_align : c_st_send;
        end
      end
      c_st_wait_align: begin
        if (abort) begin
          w_next_state = c_st_idle;
        end else if (strobe_in) begin
          w_next_state = c_st_send;
        end
      end
      c_st_send: begin
        if (abort || (r_idx == c_last_idx)) begin
          w_next_state = c_st_idle;
        end else if (GAP == 0) begin
          w_next_state = c_st_send;
        end else begin
          w_next_state = c_st_gap_wait;
        end
      end
      c_st_gap_wait: begin
        if (abort) begin
          w_next_state = c_st_idle;
        end else if (r_gap_cnt == c_gap_last) begin
          w_next_state = c_st_send;
        end
      end
      default: w_next_state = c_st_idle;
    endcase
  end

  // Output decode: bus is driven only during SEND, zero otherwise
  always_comb begin
    w_busy                 = (r_state != c_st_idle);
    settings.serial_strobe = 1'b0;
    settings.serial_addr   = 7'd0;
    settings.serial_data   = 32'd0;
    if (r_state == c_st_send) begin
      settings.serial_strobe = 1'b1;
      if (r_idx == c_last_idx) begin
        settings.serial_addr = SHIFT_ADDR;
        settings.serial_data = {24'd0, r_shift};
      end else begin
        settings.serial_addr = COEFF_ADDR;
        settings.serial_data = {12'd0, r_idx[3:0], r_coeff[r_idx[3:0]]};
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) begin
        r_coeff[i] <= 16'd0;
      end
      r_shift <= 8'd0;
    end else begin
      if (stage_we && !w_busy) begin
        r_coeff[stage_addr] <= stage_data;
      end
      if (shift_we && !w_busy) begin
        r_shift <= shift_data;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_idx     <= 5'd0;
      r_gap_cnt <= 4'd0;
    end else if (w_accept_commit) begin
      r_idx     <= 5'd0;
      r_gap_cnt <= 4'd0;
    end else if (r_state == c_st_send) begin
      r_idx     <= r_idx + 5'd1;
      r_gap_cnt <= 4'd0;
    end else if (r_state == c_st_gap_wait) begin
      r_gap_cnt <= r_gap_cnt + 4'd1;
    end
  end

  // Status flags; staging writes and the final write are never in the same cycle
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_done  <= 1'b0;
      r_dirty <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= w_last_write;
      if (w_stage_accept) begin
        r_dirty <= 1'b1;
      end else if (w_last_write) begin
        r_dirty <= 1'b0;
      end
      if (w_reject) begin
        r_err <= 1'b1;
      end else if (w_accept_commit) begin
        r_err <= 1'b0;
      end
    end
  end

  assign busy  = w_busy;
  assign done  = r_done;
  assign dirty = r_dirty;
  assign err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mrfm_iir_loader.sv
`default_nettype none
// ============================================================================
// tb_mrfm_iir_loader : directed self-checking bench for mrfm_iir_loader
// Rev 1.0
// ============================================================================
module tb_mrfm_iir_loader;

  localparam logic [6:0] c_coeff_addr = 7'h21;
  localparam logic [6:0] c_shift_addr = 7'h22;

  logic        clock;
  logic        reset;
  logic        stage_we;
  logic [3:0]  stage_addr;
  logic [15:0] stage_data;
  logic        shift_we;
  logic [7:0]  shift_data;
  logic        commit;
  logic        abort;
  logic        align_en;
  logic        strobe_in;
  logic        busy0, done0, dirty0, err0;
  logic        busy3, done3, dirty3, err3;

  mrfm_iir_loader_if bus0 ();
  mrfm_iir_loader_if bus3 ();

  mrfm_iir_loader #(.COEFF_ADDR(c_coeff_addr), .SHIFT_ADDR(c_shift_addr), .GAP(0)) dut0 (
    .clock(clock), .reset(reset), .stage_we(stage_we), .stage_addr(stage_addr),
    .stage_data(stage_data), .shift_we(shift_we), .shift_data(shift_data),
    .commit(commit), .abort(abort), .align_en(align_en), .strobe_in(strobe_in),
    .settings(bus0), .busy(busy0), .done(done0), .dirty(dirty0), .err(err0)
  );

  mrfm_iir_loader #(.COEFF_ADDR(c_coeff_addr), .SHIFT_ADDR(c_shift_addr), .GAP(3)) dut3 (
    .clock(clock), .reset(reset), .stage_we(stage_we), .stage_addr(stage_addr),
    .stage_data(stage_data), .shift_we(shift_we), .shift_data(shift_data),
    .commit(commit), .abort(abort), .align_en(align_en), .strobe_in(strobe_in),
    .settings(bus3), .busy(busy3), .done(done3), .dirty(dirty3), .err(err3)
  );

  // sel picks which instance the checks observe (0: GAP=0, 1: GAP=3)
  logic        sel;
  logic        s_strobe, s_busy, s_done, s_dirty, s_err;
  logic [6:0]  s_addr;
  logic [31:0] s_data;

  always_comb begin
    s_strobe = sel ? bus3.serial_strobe : bus0.serial_strobe;
    s_addr   = sel ? bus3.serial_addr   : bus0.serial_addr;
    s_data   = sel ? bus3.serial_data   : bus0.serial_data;
    s_busy   = sel ? busy3  : busy0;
    s_done   = sel ? done3  : done0;
    s_dirty  = sel ? dirty3 : dirty0;
    s_err    = sel ? err3   : err0;
  end

  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] m_coeff [16];
  logic [7:0]  m_shift;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) m_coeff[i] = 16'd0;
    m_shift = 8'd0;
  endtask

  task automatic stage(input logic [3:0] a, input logic [15:0] d);
    stage_we = 1'b1; stage_addr = a; stage_data = d;
    tick();
    stage_we = 1'b0;
    m_coeff[a] = d;
  endtask

  task automatic set_shift(input logic [7:0] d);
    shift_we = 1'b1; shift_data = d;
    tick();
    shift_we = 1'b0;
    m_shift = d;
  endtask

  task automatic pulse_commit();
    commit = 1'b1;
    tick();
    commit = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (s_busy && n < 200) begin
      tick();
      n++;
    end
    chk("idle_timeout", 32'(s_busy), 32'd0);
  endtask

  // Entered on the cycle of the first expected write; leaves on the done cycle + 1
  task automatic check_burst(input int gap);
    int          span;
    int          last;
    logic [4:0]  k;
    logic [6:0]  e_addr;
    logic [31:0] e_data;
    span = gap + 1;
    last = 1 + 16 * span;
    for (int c = 1; c <= last; c++) begin
      if (((c - 1) % span) == 0) begin
        k = 5'((c - 1) / span);
        if (k == 5'd16) begin
          e_addr = c_shift_addr;
          e_data = {24'd0, m_shift};
        end else begin
          e_addr = c_coeff_addr;
          e_data = {12'd0, k[3:0], m_coeff[k[3:0]]};
        end
        chk("burst_strobe", 32'(s_strobe), 32'd1);
        chk("burst_addr", 32'(s_addr), 32'(e_addr));
        chk("burst_data", s_data, e_data);
      end else begin
        chk("gap_strobe", 32'(s_strobe), 32'd0);
        chk("gap_data", s_data, 32'd0);
      end
      chk("burst_busy", 32'(s_busy), 32'd1);
      tick();
    end
    chk("done_pulse", 32'(s_done), 32'd1);
    chk("done_busy", 32'(s_busy), 32'd0);
    chk("done_dirty", 32'(s_dirty), 32'd0);
    chk("done_strobe", 32'(s_strobe), 32'd0);
    tick();
    chk("done_single", 32'(s_done), 32'd0);
  endtask

  initial begin
    logic seen_strobe;
    logic seen_done;
    reset = 1'b1; stage_we = 1'b0; stage_addr = 4'd0; stage_data = 16'd0;
    shift_we = 1'b0; shift_data = 8'd0; commit = 1'b0; abort = 1'b0;
    align_en = 1'b0; strobe_in = 1'b0; sel = 1'b0;
    model_clear();
    tick();
    tick();
    chk("rst_strobe", 32'(s_strobe), 32'd0);
    chk("rst_addr", 32'(s_addr), 32'd0);
    chk("rst_data", s_data, 32'd0);
    chk("rst_busy", 32'(s_busy), 32'd0);
    chk("rst_done", 32'(s_done), 32'd0);
    chk("rst_dirty", 32'(s_dirty), 32'd0);
    chk("rst_err", 32'(s_err), 32'd0);
    reset = 1'b0;
    tick();

    // Basic burst: coeff[3]=1234, shift=15, strobes at cycles 1..17, done at 18
    stage(4'd3, 16'h1234);
    chk("stage_dirty", 32'(s_dirty), 32'd1);
    set_shift(8'd15);
    pulse_commit();
    check_burst(0);

    // Aligned burst, nothing newly staged; strobe_in 10 cycles after commit
    align_en = 1'b1;
    pulse_commit();
    for (int i = 1; i <= 9; i++) begin
      chk("align_hold_strobe", 32'(s_strobe), 32'd0);
      chk("align_hold_busy", 32'(s_busy), 32'd1);
      tick();
    end
    strobe_in = 1'b1;
    chk("align_edge_strobe", 32'(s_strobe), 32'd0);
    tick();
    strobe_in = 1'b0;
    align_en = 1'b0;
    check_burst(0);

    // Staging write during a burst is rejected and flags err
    pulse_commit();
    stage_we = 1'b1; stage_addr = 4'd3; stage_data = 16'hFFFF;
    tick();
    stage_we = 1'b0;
    chk("reject_err", 32'(s_err), 32'd1);
    wait_idle();
    chk("err_sticky", 32'(s_err), 32'd1);
    chk("reject_no_dirty", 32'(s_dirty), 32'd0);
    pulse_commit();
    chk("commit_clears_err", 32'(s_err), 32'd0);
    check_burst(0);

    // Abort on the 5th strobe
    stage(4'd5, 16'h5555);
    pulse_commit();
    repeat (4) tick();
    chk("abort_5th_strobe", 32'(s_strobe), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_no_6th", 32'(s_strobe), 32'd0);
    chk("abort_busy", 32'(s_busy), 32'd0);
    seen_strobe = 1'b0;
    seen_done = 1'b0;
    repeat (20) begin
      seen_strobe = seen_strobe | s_strobe;
      seen_done = seen_done | s_done;
      tick();
    end
    chk("abort_quiet_strobe", 32'(seen_strobe), 32'd0);
    chk("abort_no_done", 32'(seen_done), 32'd0);
    chk("abort_dirty", 32'(s_dirty), 32'd1);

    // Abort beats commit in the same idle cycle
    abort = 1'b1; commit = 1'b1;
    tick();
    abort = 1'b0; commit = 1'b0;
    chk("abort_commit_busy", 32'(s_busy), 32'd0);
    tick();
    chk("abort_commit_strobe", 32'(s_strobe), 32'd0);

    // Staging write together with commit is carried in the burst
    stage_we = 1'b1; stage_addr = 4'd0; stage_data = 16'hBEEF; commit = 1'b1;
    m_coeff[0] = 16'hBEEF;
    tick();
    stage_we = 1'b0; commit = 1'b0;
    check_burst(0);

    // Asynchronous reset mid-burst
    stage(4'd7, 16'h7777);
    pulse_commit();
    shift_we = 1'b1; shift_data = 8'h99;
    tick();
    shift_we = 1'b0;
    chk("pre_rst_err", 32'(s_err), 32'd1);
    tick();
    #2;
    reset = 1'b1;
    #1;
    chk("arst_strobe", 32'(s_strobe), 32'd0);
    chk("arst_addr", 32'(s_addr), 32'd0);
    chk("arst_data", s_data, 32'd0);
    chk("arst_busy", 32'(s_busy), 32'd0);
    chk("arst_dirty", 32'(s_dirty), 32'd0);
    chk("arst_err", 32'(s_err), 32'd0);
    tick();
    reset = 1'b0;
    model_clear();
    seen_done = 1'b0;
    repeat (5) begin
      seen_done = seen_done | s_done;
      tick();
    end
    chk("arst_no_done", 32'(seen_done), 32'd0);
    pulse_commit();
    check_burst(0);

    // GAP=3 instance: spacing 4, last strobe at 65, done at 66
    sel = 1'b1;
    do_reset();
    model_clear();
    stage(4'd15, 16'hABCD);
    set_shift(8'hA5);
    pulse_commit();
    check_burst(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
